// File: rtl/tlb_array_n.sv
// tlb_array_n: fully associative N-entry TLB with registered dual lookup, CP0 read/write and Wired/Random replacement.
// Optional probe port enabled by defining TLB_PROBE_EN.
module tlb_array_n #(
    parameter int ENTRIES = 16,
    parameter int ASID_W = 8,
    parameter int PAGE_BITS = 12,
    localparam int IDX_W = $clog2(ENTRIES),
    localparam int VPN_W = 32 - PAGE_BITS,
    localparam int PFN_W = 32 - PAGE_BITS,
    localparam int E_W = VPN_W + ASID_W + PFN_W + 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic [ASID_W-1:0] ASID,
    input  logic              I_EN,
    input  logic [31:0]       I_VA,
    input  logic              D_RD,
    input  logic              D_WR,
    input  logic [31:0]       D_VA,
    output logic [31:0]       I_PA,
    output logic [31:0]       D_PA,
    output logic              iTLBL,
    output logic              dTLBL,
    output logic              dTLBS,
    output logic              dTLBMOD,
    input  logic              TLB_WE,
    input  logic              TLB_WI,
    input  logic [IDX_W-1:0]  INDEX,
    input  logic [E_W-1:0]    WR_ENTRY,
    input  logic              TLB_RD,
    output logic [E_W-1:0]    RD_ENTRY,
    input  logic              WIRED_WE,
    input  logic [IDX_W-1:0]  WIRED_D,
    output logic [IDX_W-1:0]  RANDOM,
    input  logic              PROBE,
    output logic [IDX_W-1:0]  PROBE_IDX,
    output logic              PROBE_MISS
);
    localparam int PFN_L = 2;
    localparam int G_B = PFN_W + 2;
    localparam int ASID_L = PFN_W + 3;
    localparam int VPN_L = PFN_W + 3 + ASID_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    logic [E_W-1:0] tlb [ENTRIES];
    logic [IDX_W-1:0] wired;
    logic [ENTRIES-1:0] m_i, m_d;
    logic [E_W-1:0] e_i, e_d;
    logic ok_i, ok_d;
    logic [31:0] pa_i, pa_d;

    function automatic logic tag_hit(input logic [E_W-1:0] e, input logic [VPN_W-1:0] vpn,
                                     input logic [ASID_W-1:0] asid);
        return e[VPN_L +: VPN_W] == vpn && (e[G_B] || e[ASID_L +: ASID_W] == asid);
    endfunction

    function automatic logic [IDX_W-1:0] first(input logic [ENTRIES-1:0] m);
        first = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (m[i]) first = IDX_W'(i);
    endfunction

    // Only valid entries compete, so a stale duplicate never shadows a live mapping.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_match
        assign m_i[g] = tlb[g][0] && tag_hit(tlb[g], I_VA[31:PAGE_BITS], ASID);
        assign m_d[g] = tlb[g][0] && tag_hit(tlb[g], D_VA[31:PAGE_BITS], ASID);
    end

    assign e_i = tlb[first(m_i)];
    assign e_d = tlb[first(m_d)];
    assign ok_i = |m_i;
    assign ok_d = |m_d;
    assign pa_i = ok_i ? {e_i[PFN_L +: PFN_W], I_VA[PAGE_BITS-1:0]} : '0;
    assign pa_d = ok_d ? {e_d[PFN_L +: PFN_W], D_VA[PAGE_BITS-1:0]} : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) tlb[i] <= '0;
            I_PA <= '0;
            D_PA <= '0;
            iTLBL <= 1'b0;
            dTLBL <= 1'b0;
            dTLBS <= 1'b0;
            dTLBMOD <= 1'b0;
            RD_ENTRY <= '0;
            wired <= '0;
            RANDOM <= LAST;
        end else begin
            if (!STALL) begin
                I_PA <= pa_i;
                D_PA <= pa_d;
                iTLBL <= I_EN && !ok_i;
                dTLBL <= D_RD && !D_WR && !ok_d;
                dTLBS <= D_WR && !ok_d;
                dTLBMOD <= D_WR && ok_d && !e_d[1];
            end
            if (TLB_WE) tlb[TLB_WI ? INDEX : RANDOM] <= WR_ENTRY;
            if (TLB_RD) RD_ENTRY <= tlb[INDEX];
            if (WIRED_WE) wired <= WIRED_D;
            RANDOM <= (WIRED_WE || wired >= LAST || RANDOM <= wired) ? LAST : RANDOM - 1'b1;
        end
    end

`ifdef TLB_PROBE_EN
    logic [ENTRIES-1:0] m_p;
    for (genvar g = 0; g < ENTRIES; g++) begin : g_probe
        assign m_p[g] = tag_hit(tlb[g], WR_ENTRY[VPN_L +: VPN_W], WR_ENTRY[ASID_L +: ASID_W]);
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PROBE_IDX <= '0;
            PROBE_MISS <= 1'b0;
        end else if (PROBE) begin
            PROBE_IDX <= first(m_p);
            PROBE_MISS <= ~|m_p;
        end
    end
`else
    logic unused_probe;
    assign unused_probe = PROBE;
    assign PROBE_IDX = '0;
    assign PROBE_MISS = 1'b0;
`endif
endmodule
